// File: rtl/cpu_sequencer.sv
// ----------------------------------------------------------------------------
// cpu_sequencer
//
// Multi-cycle control sequencer for the 8-bit CPU. Each instruction is
// stepped through FETCH -> DECODE -> EXEC/MEM -> WB under a memory handshake,
// and program counter, memory, register-file and ALU controls are decoded
// from the current state and the registered instruction byte.
//
// Optional feature macro: CPU_SEQ_JC_EN
//   defined   : JC (111xxx10) loads the PC when carry_flag is set
//   undefined : JC behaves as a NOP (DECODE -> EXEC -> FETCH, no pc_load)
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   run          in   permission to start a new fetch (looked at in FETCH)
//   instruction  in   [7:0] memory read data, valid with mem_ready
//   mem_ready    in   memory completes the current request this cycle
//   alu_carry    in   ALU carry-out, captured at the end of EXEC
//   mem_req      out  memory request, held until mem_ready
//   mem_read     out  request is a read (fetch or LOAD)
//   mem_write    out  request is a write (STORE)
//   addr_sel     out  0 = address from PC, 1 = address from register data1
//   pc_increment out  PC+1 strobe (DECODE)
//   pc_load      out  PC load strobe (JMP/JC in EXEC)
//   reg_write    out  register-file write strobe (WB)
//   wb_sel       out  0 = ALU result, 1 = memory data
//   alu_op       out  [2:0] ALU operation, IR[7:5] during EXEC
//   ir           out  [7:0] registered instruction
//   carry_flag   out  carry captured by the last ALU instruction
//   state        out  [2:0] current FSM state
//   halted       out  high while in HALT
// ----------------------------------------------------------------------------
module cpu_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [7:0] instruction,
  input  logic       mem_ready,
  input  logic       alu_carry,
  output logic       mem_req,
  output logic       mem_read,
  output logic       mem_write,
  output logic       addr_sel,
  output logic       pc_increment,
  output logic       pc_load,
  output logic       reg_write,
  output logic       wb_sel,
  output logic [2:0] alu_op,
  output logic [7:0] ir,
  output logic       carry_flag,
  output logic [2:0] state,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_ir;
  logic       r_carry;
  logic       r_fetch_pend;

  logic [2:0] w_opc;
  logic       w_is_alu;
  logic       w_is_load;
  logic       w_is_store;
  logic       w_is_ctrl;
  logic       w_is_halt;
  logic       w_is_jc;
  logic       w_fetch_req;
  logic       w_jc_take;

  assign w_opc      = r_ir[7:5];
  assign w_is_alu   = (w_opc <= 3'd4);
  assign w_is_load  = (w_opc == 3'd5);
  assign w_is_store = (w_opc == 3'd6);
  assign w_is_ctrl  = (w_opc == 3'd7);
  assign w_is_halt  = w_is_ctrl & r_ir[0];
  assign w_is_jc    = w_is_ctrl & ~r_ir[0] & r_ir[1];

`ifdef CPU_SEQ_JC_EN
  assign w_jc_take  = r_carry;
`else
  assign w_jc_take  = 1'b0;
`endif

  // A fetch, once started, stays requested even if run drops; reset kills it
  // immediately so mem_req falls without waiting for a clock edge.
  assign w_fetch_req = (run | r_fetch_pend) & ~reset;

  // State, instruction and carry registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_FETCH;
      r_ir         <= 8'h00;
      r_carry      <= 1'b0;
      r_fetch_pend <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_fetch_pend <= (r_state == S_FETCH) && w_fetch_req && !mem_ready;
      if ((r_state == S_FETCH) && w_fetch_req && mem_ready) begin
        r_ir <= instruction;
      end
      if ((r_state == S_EXEC) && w_is_alu) begin
        r_carry <= alu_carry;
      end
    end
  end

  // Next-state and Moore output decode.
  always_comb begin
    w_next       = S_FETCH;
    mem_req      = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    addr_sel     = 1'b0;
    pc_increment = 1'b0;
    pc_load      = 1'b0;
    reg_write    = 1'b0;
    wb_sel       = 1'b0;
    alu_op       = 3'd0;
    halted       = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req  = w_fetch_req;
        mem_read = w_fetch_req;
        if (w_fetch_req && mem_ready) begin
          w_next = S_DECODE;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_DECODE: begin
        pc_increment = 1'b1;
        if (w_is_load || w_is_store) begin
          w_next = S_MEM;
        end else if (w_is_halt) begin
          w_next = S_HALT;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_op = w_opc;
        if (w_is_alu) begin
          w_next = S_WB;
        end else begin
          // JMP always loads; JC loads only when taken.
          pc_load = w_is_jc ? w_jc_take : w_is_ctrl;
          w_next  = S_FETCH;
        end
      end
      S_MEM: begin
        mem_req   = 1'b1;
        addr_sel  = 1'b1;
        mem_read  = w_is_load;
        mem_write = w_is_store;
        if (!mem_ready) begin
          w_next = S_MEM;
        end else if (w_is_load) begin
          w_next = S_WB;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        wb_sel    = w_is_load;
        w_next    = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
        w_next = S_HALT;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  assign ir         = r_ir;
  assign carry_flag = r_carry;
  assign state      = r_state;

endmodule

// File: tb/tb_cpu_sequencer.sv
// ----------------------------------------------------------------------------
// tb_cpu_sequencer
//
// Scoreboarded bench for cpu_sequencer. The stimulus side walks instructions
// at the phase level (fetch with N waits, decode, execute, memory with N
// waits, writeback, halt) and pushes the expected output vector of every
// cycle into a queue; a monitor on the falling edge pops and compares.
// ----------------------------------------------------------------------------
module tb_cpu_sequencer;

  logic       clk;
  logic       reset;
  logic       run;
  logic [7:0] instruction;
  logic       mem_ready;
  logic       alu_carry;
  logic       mem_req;
  logic       mem_read;
  logic       mem_write;
  logic       addr_sel;
  logic       pc_increment;
  logic       pc_load;
  logic       reg_write;
  logic       wb_sel;
  logic [2:0] alu_op;
  logic [7:0] ir;
  logic       carry_flag;
  logic [2:0] state;
  logic       halted;

`ifdef CPU_SEQ_JC_EN
  localparam bit JC_EN = 1'b1;
`else
  localparam bit JC_EN = 1'b0;
`endif

  cpu_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .instruction  (instruction),
    .mem_ready    (mem_ready),
    .alu_carry    (alu_carry),
    .mem_req      (mem_req),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .addr_sel     (addr_sel),
    .pc_increment (pc_increment),
    .pc_load      (pc_load),
    .reg_write    (reg_write),
    .wb_sel       (wb_sel),
    .alu_op       (alu_op),
    .ir           (ir),
    .carry_flag   (carry_flag),
    .state        (state),
    .halted       (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model architectural state.
  logic [7:0]  m_ir;
  logic        m_carry;
  logic [23:0] exp_q[$];
  int          n_vec;
  int          n_err;
  int          n_cyc;

  // Expected vector: {state, req, rd, wr, asel, inc, ld, rw, wbs, aluop, halted, ir, carry}
  function automatic logic [23:0] mk(input logic [2:0] st, input logic rq, input logic rd,
                                     input logic wr, input logic as, input logic inc,
                                     input logic ld, input logic rw, input logic wb,
                                     input logic [2:0] aop, input logic h);
    return {st, rq, rd, wr, as, inc, ld, rw, wb, aop, h, m_ir, m_carry};
  endfunction

  // One clock of stimulus with the outputs expected during it.
  task automatic cyc(input logic rs, input logic rn, input logic mr, input logic ac,
                     input logic [23:0] e);
    reset       = rs;
    run         = rn;
    mem_ready   = mr;
    alu_carry   = ac;
    instruction = 8'($urandom);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_cyc(input logic [23:0] e);
    cyc(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b0, 1'($urandom), 1'($urandom), mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 0));
    end
  endtask

  task automatic do_reset(input int n);
    m_ir    = 8'h00;
    m_carry = 1'b0;
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'($urandom), 1'($urandom), 1'($urandom),
          mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 0));
    end
  endtask

  // Fetch with wf wait cycles; run may drop once the fetch is pending.
  task automatic do_fetch(input logic [7:0] ins, input int wf);
    logic [23:0] e;
    e = mk(3'd0, 1, 1, 0, 0, 0, 0, 0, 0, 3'd0, 0);
    for (int w = 0; w < wf; w++) begin
      cyc(1'b0, (w == 0) ? 1'b1 : 1'($urandom), 1'b0, 1'($urandom), e);
    end
    reset       = 1'b0;
    run         = (wf == 0) ? 1'b1 : 1'($urandom);
    mem_ready   = 1'b1;
    alu_carry   = 1'($urandom);
    instruction = ins;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    m_ir = ins;
  endtask

  // Complete instruction; halt_cycles used only for HALT.
  task automatic do_instr(input logic [7:0] ins, input int wf, input int wm,
                          input logic ac, input int halt_cycles);
    logic [2:0] op;
    logic       ld;
    op = ins[7:5];
    do_fetch(ins, wf);
    rnd_cyc(mk(3'd1, 0, 0, 0, 0, 1, 0, 0, 0, 3'd0, 0));
    if (op <= 3'd4) begin
      cyc(1'b0, 1'($urandom), 1'($urandom), ac, mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, op, 0));
      m_carry = ac;
      rnd_cyc(mk(3'd4, 0, 0, 0, 0, 0, 0, 1, 0, 3'd0, 0));
    end else if (op == 3'd5 || op == 3'd6) begin
      for (int w = 0; w < wm; w++) begin
        cyc(1'b0, 1'($urandom), 1'b0, 1'($urandom),
            mk(3'd3, 1, op == 3'd5, op == 3'd6, 1, 0, 0, 0, 0, 3'd0, 0));
      end
      cyc(1'b0, 1'($urandom), 1'b1, 1'($urandom),
          mk(3'd3, 1, op == 3'd5, op == 3'd6, 1, 0, 0, 0, 0, 3'd0, 0));
      if (op == 3'd5) begin
        rnd_cyc(mk(3'd4, 0, 0, 0, 0, 0, 0, 1, 1, 3'd0, 0));
      end
    end else if (ins[0]) begin
      for (int i = 0; i < halt_cycles; i++) begin
        cyc(1'b0, 1'($urandom), i[0], 1'($urandom), mk(3'd5, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 1));
      end
    end else begin
      ld = ins[1] ? (JC_EN & m_carry) : 1'b1;
      rnd_cyc(mk(3'd2, 0, 0, 0, 0, 0, ld, 0, 0, 3'd7, 0));
    end
  endtask

  // Scoreboard monitor: compare every cycle that has an expectation queued.
  always @(negedge clk) begin
    logic [23:0] e;
    logic [23:0] a;
    n_cyc = n_cyc + 1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = {state, mem_req, mem_read, mem_write, addr_sel, pc_increment, pc_load,
           reg_write, wb_sel, alu_op, halted, ir, carry_flag};
      n_vec = n_vec + 1;
      if (a !== e) begin
        n_err = n_err + 1;
        $display("FAIL outputs @%0t: act st=%0d rq%b rd%b wr%b as%b inc%b ld%b rw%b wb%b op%0d h%b ir=%h c%b / exp st=%0d rq%b rd%b wr%b as%b inc%b ld%b rw%b wb%b op%0d h%b ir=%h c%b",
                 $time, a[23:21], a[20], a[19], a[18], a[17], a[16], a[15], a[14], a[13],
                 a[12:10], a[9], a[8:1], a[0], e[23:21], e[20], e[19], e[18], e[17],
                 e[16], e[15], e[14], e[13], e[12:10], e[9], e[8:1], e[0]);
      end
    end
  end

  initial begin
    logic [7:0] ins;
    n_vec       = 0;
    n_err       = 0;
    n_cyc       = 0;
    m_ir        = 8'h00;
    m_carry     = 1'b0;
    reset       = 1'b1;
    run         = 1'b0;
    mem_ready   = 1'b0;
    alu_carry   = 1'b0;
    instruction = 8'h00;
    @(posedge clk);
    #1;
    do_reset(2);
    idle(2);

    // ADD zero-wait, then LOAD with three memory waits, then STORE.
    do_instr(8'h00, 0, 0, 1'b0, 0);
    do_instr(8'hA0, 0, 3, 1'b0, 0);
    do_instr(8'hC0, 0, 0, 1'b0, 0);
    // JC taken / not taken after carry-producing ADDs; plain JMP.
    do_instr(8'h00, 1, 0, 1'b1, 0);
    do_instr(8'hE2, 0, 0, 1'b0, 0);
    do_instr(8'h20, 0, 0, 1'b0, 0);
    do_instr(8'hE2, 2, 0, 1'b1, 0);
    do_instr(8'hE0, 0, 0, 1'b0, 0);

    // Reset in the middle of a waiting LOAD.
    do_fetch(8'hA5, 1);
    rnd_cyc(mk(3'd1, 0, 0, 0, 0, 1, 0, 0, 0, 3'd0, 0));
    cyc(1'b0, 1'b1, 1'b0, 1'b0, mk(3'd3, 1, 1, 0, 1, 0, 0, 0, 0, 3'd0, 0));
    do_reset(1);
    idle(1);

    // Randomized instruction stream (no HALT).
    for (int k = 0; k < 60; k++) begin
      ins = 8'($urandom);
      if (ins[7:5] == 3'd7) ins[0] = 1'b0;
      do_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    // HALT held for 20 cycles with mem_ready toggling, then reset out of it.
    do_instr(8'hE1, 0, 0, 1'b0, 20);
    do_reset(1);
    idle(2);

    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_err = n_err + 1;
      $display("FAIL drain: act %0d pending expectations, exp 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control sequencer for the 8-bit CPU. It steps each instruction through fetch, decode, execute, memory and writeback, and drives program counter, memory, register-file and ALU control from one registered instruction byte. It replaces the free-running always-increment PC and always-enabled register write with a handshaked FSM, so memory latency and halts are handled explicitly.

## Interface
- No parameters; widths fixed (8-bit instruction, 3-bit ALU op).
- clk  input  1  single system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- run  input  1  1 = may start a new fetch; sampled only in FETCH
- instruction  input  8  memory read data, valid when mem_ready=1
- mem_ready  input  1  memory completes the current request this cycle
- alu_carry  input  1  ALU carry-out, sampled at end of EXEC
- mem_req  output  1  memory request, held until mem_ready
- mem_read  output  1  request is a read (fetch or LOAD)
- mem_write  output  1  request is a write (STORE)
- addr_sel  output  1  0 = address from PC, 1 = address from register data1
- pc_increment  output  1  one-cycle PC+1 strobe
- pc_load  output  1  one-cycle PC load strobe (JMP/JC)
- reg_write  output  1  one-cycle register-file write strobe
- wb_sel  output  1  0 = writeback ALU result, 1 = memory data
- alu_op  output  3  ALU operation from IR[7:5]
- ir  output  8  registered instruction
- carry_flag  output  1  registered carry from last ALU instruction
- state  output  3  current FSM state encoding
- halted  output  1  1 while in HALT

## Operation
- Opcode IR[7:5]: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR (ALU, writeback); 101 LOAD; 110 STORE; 111 control: IR[0]=1 HALT, else IR[1]=1 JC, else JMP.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Codes 6 and 7 are illegal and go to FETCH on the next edge.
- FETCH: if run=0, idle with mem_req=0. If run=1, drive mem_req=1, mem_read=1, addr_sel=0. When mem_ready=1, load ir from instruction and go to DECODE.
- DECODE: pc_increment=1 for one cycle. Next state: ALU op or JMP/JC -> EXEC; LOAD/STORE -> MEM; HALT -> HALT.
- EXEC: alu_op=IR[7:5]. For ALU ops, carry_flag<=alu_carry and go to WB. For JMP, pc_load=1. For JC, pc_load=carry_flag. JMP/JC then go to FETCH.
- MEM: mem_req=1, addr_sel=1, with mem_read=1 for LOAD or mem_write=1 for STORE. Hold until mem_ready=1. LOAD then goes to WB; STORE goes to FETCH.
- WB: reg_write=1 for one cycle; wb_sel=1 for LOAD, 0 for ALU. Next state is FETCH.
- HALT: all strobes 0, halted=1; left only by reset.
- Outputs are Moore decodes of state and ir. mem_req, mem_read and mem_write stay stable until mem_ready.

## Timing
- Reset values: state=FETCH, ir=8'h00, carry_flag=0. All strobes, mem_req, mem_read, mem_write, addr_sel, wb_sel and halted are 0; alu_op=0.
- Latency with zero-wait memory (mem_ready high in the first request cycle): ALU 4 cycles; LOAD 4; STORE 3; JMP/JC 3; HALT enters after 2.
- Each wait cycle (mem_ready=0 while mem_req=1) adds one cycle. Request outputs hold unchanged.
- mem_ready while mem_req=0 is ignored.
- pc_increment in DECODE comes before pc_load in EXEC, so the jump target overrides the incremented PC.
- Reset mid-request: mem_req drops asynchronously; the partial transaction is abandoned.
- run deasserting during a pending fetch does not cancel it. run is re-checked only on a new FETCH entry.

## Configuration
- CPU_SEQ_JC_EN defined: JC is implemented as described.
- CPU_SEQ_JC_EN undefined: JC decodes as NOP, passing DECODE -> EXEC -> FETCH with no pc_load; carry_flag is still updated by ALU ops.

## Test plan
- Reset check: reset=1 mid-MEM -> next cycle state=0, mem_req=0, ir=00, carry_flag=0.
- ADD fetch: run=1, zero-wait memory returns 8'h00 (ADD) -> state sequence 0,1,2,4,0; one pc_increment in cycle 2; one reg_write in cycle 4 with wb_sel=0; alu_op=0.
- LOAD with wait: instruction 8'hA0, mem_ready low 3 cycles in MEM -> mem_req/mem_read/addr_sel=1 held; reg_write with wb_sel=1 exactly once, 7 cycles total.
- STORE 8'hC0 -> mem_write=1 with addr_sel=1 in MEM, no reg_write, return to FETCH.
- JC (macro on): ADD with alu_carry=1, then JC 8'hE2 -> pc_load=1. With carry_flag=0 -> pc_load=0. Macro off -> pc_load never asserts.
- HALT 8'hE1 -> halted=1 and state=5 held for 20 cycles with mem_ready toggling; reset returns to FETCH.
